// File: rtl/cdb_arbiter_if.sv
// Bundle between the functional units and the CDB arbiter: per-unit result
// strobes in, occupancy hints and the registered broadcast out.
interface cdb_arbiter_if #(
  parameter int NUM_FU = 8,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 32
);
  localparam int CNT_W = $clog2(NUM_FU + 1);

  logic [NUM_FU-1:0]             fu_valid;
  logic [NUM_FU-1:0][DATA_W-1:0] fu_data;
  logic [NUM_FU-1:0]             fu_hold;
  logic                          cdb_valid;
  logic [TAG_W-1:0]              cdb_tag;
  logic [DATA_W-1:0]             cdb_data;
  logic [CNT_W-1:0]              pending_count;
  logic                          overflow;

  modport master (
    output fu_valid, fu_data,
    input  fu_hold, cdb_valid, cdb_tag, cdb_data, pending_count, overflow
  );

  modport slave (
    input  fu_valid, fu_data,
    output fu_hold, cdb_valid, cdb_tag, cdb_data, pending_count, overflow
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: per-unit holding slots granted round-robin onto a
// registered (tag, value) broadcast; tag 0 is reserved and never broadcast.
module cdb_arbiter #(
  parameter int NUM_FU = 8,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 32
) (
  input logic          CLOCK_50,
  input logic          RSTN_N,
  cdb_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(NUM_FU + 1);

  logic [NUM_FU-1:1]             occ, occ_next;
  logic [NUM_FU-1:1][DATA_W-1:0] slot, slot_next;
  logic [NUM_FU-1:1]             cand, grant_oh;
  logic [TAG_W-1:0]              rr_ptr, grant_idx, hi_idx, lo_idx;
  logic                          hi_hit, lo_hit, found, drop;
  logic [DATA_W-1:0]             grant_data;
  logic [CNT_W-1:0]              count_next;
  logic                          cdb_valid_q;
  logic [TAG_W-1:0]              cdb_tag_q;
  logic [DATA_W-1:0]             cdb_data_q;
  logic [CNT_W-1:0]              pending_q;
  logic                          overflow_q;
  logic                          unused_bits;

  assign unused_bits = ^{bus.fu_valid[0], bus.fu_data[0]};
  assign cand        = occ | bus.fu_valid[NUM_FU-1:1];

  // Descending scans leave the lowest candidate at or above rr_ptr (hi) and
  // the lowest one below it (lo); hi wins, giving the ring order.
  always_comb begin
    hi_hit = 1'b0;
    lo_hit = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = NUM_FU - 1; i >= 1; i--) begin
      if (cand[i] && (i >= int'(rr_ptr))) begin
        hi_hit = 1'b1;
        hi_idx = TAG_W'(i);
      end
      if (cand[i] && (i < int'(rr_ptr))) begin
        lo_hit = 1'b1;
        lo_idx = TAG_W'(i);
      end
    end
    found     = hi_hit | lo_hit;
    grant_idx = hi_hit ? hi_idx : lo_idx;
  end

  always_comb begin
    grant_oh   = '0;
    grant_data = '0;
    occ_next   = occ;
    slot_next  = slot;
    drop       = 1'b0;
    count_next = '0;
    for (int i = 1; i < NUM_FU; i++) begin
      grant_oh[i] = found && (grant_idx == TAG_W'(i));
      if (grant_oh[i]) begin
        grant_data = occ[i] ? slot[i] : bus.fu_data[i];
      end
      // A granted occupied slot refills from a same-cycle strobe; an
      // ungranted occupied slot keeps its older value and the new one is lost.
      if (bus.fu_valid[i]) begin
        if (grant_oh[i]) begin
          if (occ[i]) begin
            slot_next[i] = bus.fu_data[i];
          end
        end else if (occ[i]) begin
          drop = 1'b1;
        end else begin
          occ_next[i]  = 1'b1;
          slot_next[i] = bus.fu_data[i];
        end
      end else if (grant_oh[i]) begin
        occ_next[i] = 1'b0;
      end
      count_next = count_next + CNT_W'(occ_next[i]);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RSTN_N) begin
    if (!RSTN_N) begin
      occ         <= '0;
      slot        <= '0;
      rr_ptr      <= TAG_W'(1);
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      pending_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      occ         <= occ_next;
      slot        <= slot_next;
      pending_q   <= count_next;
      cdb_valid_q <= found;
      cdb_tag_q   <= grant_idx;
      cdb_data_q  <= grant_data;
      if (drop) begin
        overflow_q <= 1'b1;
      end
      if (found) begin
        rr_ptr <= (grant_idx == TAG_W'(NUM_FU - 1)) ? TAG_W'(1) : grant_idx + TAG_W'(1);
      end
    end
  end

  assign bus.fu_hold       = {occ, 1'b0};
  assign bus.cdb_valid     = cdb_valid_q;
  assign bus.cdb_tag       = cdb_tag_q;
  assign bus.cdb_data      = cdb_data_q;
  assign bus.pending_count = pending_q;
  assign bus.overflow      = overflow_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table, reset corner sequence, then
// random strobes compared against a ring-walk reference model.
module tb_cdb_arbiter;
  localparam int NUM_FU     = 8;
  localparam int TAG_W      = 3;
  localparam int DATA_W     = 32;
  localparam int FAIR_BOUND = NUM_FU - 2;

  typedef logic [NUM_FU-1:0][DATA_W-1:0] data_vec_t;

  typedef struct {
    logic [NUM_FU-1:0] v;
    logic [31:0]       dv;
    logic              e_valid;
    int                e_tag;
    logic [31:0]       e_data;
    logic [NUM_FU-1:0] e_hold;
    int                e_pend;
    logic              e_ovf;
  } vec_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  cdb_arbiter_if #(.NUM_FU(NUM_FU), .TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

  cdb_arbiter #(.NUM_FU(NUM_FU), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .CLOCK_50 (clk),
    .RSTN_N   (rstn),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  vec_t tbl[$];

  bit          m_occ[NUM_FU];
  logic [31:0] m_slot[NUM_FU];
  int          m_rr;
  bit          m_ovf;
  logic        m_valid;
  int          m_tag;
  logic [31:0] m_data;
  int          wait_cnt[NUM_FU];

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic e_valid, input int e_tag,
                             input logic [31:0] e_data, input logic [NUM_FU-1:0] e_hold,
                             input int e_pend, input logic e_ovf);
    checkVal({name, " cdb_valid"}, 32'(bus.cdb_valid), 32'(e_valid));
    checkVal({name, " cdb_tag"}, 32'(bus.cdb_tag), 32'(e_tag));
    checkVal({name, " cdb_data"}, bus.cdb_data, e_data);
    checkVal({name, " fu_hold"}, 32'(bus.fu_hold), 32'(e_hold));
    checkVal({name, " pending_count"}, 32'(bus.pending_count), 32'(e_pend));
    checkVal({name, " overflow"}, 32'(bus.overflow), 32'(e_ovf));
  endtask

  task automatic applyStimulus(input logic [NUM_FU-1:0] v, input data_vec_t d);
    bus.fu_valid = v;
    bus.fu_data  = d;
    @(posedge clk);
    #1;
    bus.fu_valid = '0;
  endtask

  function automatic data_vec_t mk_data(input logic [31:0] dv);
    data_vec_t d;
    for (int i = 0; i < NUM_FU; i++) d[i] = dv + 32'(i);
    return d;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NUM_FU; i++) begin
      m_occ[i]    = 1'b0;
      m_slot[i]   = '0;
      wait_cnt[i] = 0;
    end
    m_rr  = 1;
    m_ovf = 1'b0;
  endfunction

  // Walk the ring of units 1..NUM_FU-1 starting at m_rr; first candidate wins.
  function automatic void model_step(input logic [NUM_FU-1:0] v, input data_vec_t d);
    int g;
    int idx;
    g = 0;
    for (int off = 0; off < NUM_FU - 1; off++) begin
      idx = (m_rr - 1 + off) % (NUM_FU - 1) + 1;
      if (g == 0 && (m_occ[idx] || v[idx])) g = idx;
    end
    m_valid = (g != 0);
    m_tag   = g;
    m_data  = (g == 0) ? 32'h0 : (m_occ[g] ? m_slot[g] : d[g]);
    if (g != 0) m_rr = g % (NUM_FU - 1) + 1;
    for (int i = 1; i < NUM_FU; i++) begin
      if (v[i]) begin
        if (i == g) begin
          if (m_occ[i]) m_slot[i] = d[i];
        end else if (m_occ[i]) begin
          m_ovf = 1'b1;
        end else begin
          m_occ[i]  = 1'b1;
          m_slot[i] = d[i];
        end
      end else if (i == g) begin
        m_occ[i] = 1'b0;
      end
    end
  endfunction

  function automatic logic [NUM_FU-1:0] model_hold();
    logic [NUM_FU-1:0] h;
    h = '0;
    for (int i = 1; i < NUM_FU; i++) h[i] = m_occ[i];
    return h;
  endfunction

  function automatic int model_pend();
    int c;
    c = 0;
    for (int i = 1; i < NUM_FU; i++) c += int'(m_occ[i]);
    return c;
  endfunction

  initial begin
    bus.fu_valid = '0;
    bus.fu_data  = '0;

    // Unit data is dv + unit index for every strobing unit in a vector.
    tbl.push_back(vec_t'{v:8'h08, dv:32'h02, e_valid:1'b1, e_tag:3, e_data:32'h05, e_hold:8'h00, e_pend:0, e_ovf:1'b0});
    tbl.push_back(vec_t'{v:8'h80, dv:32'h70, e_valid:1'b1, e_tag:7, e_data:32'h77, e_hold:8'h00, e_pend:0, e_ovf:1'b0});
    tbl.push_back(vec_t'{v:8'h00, dv:32'h00, e_valid:1'b0, e_tag:0, e_data:32'h00, e_hold:8'h00, e_pend:0, e_ovf:1'b0});
    tbl.push_back(vec_t'{v:8'h64, dv:32'h1E, e_valid:1'b1, e_tag:2, e_data:32'h20, e_hold:8'h60, e_pend:2, e_ovf:1'b0});
    tbl.push_back(vec_t'{v:8'h00, dv:32'h00, e_valid:1'b1, e_tag:5, e_data:32'h23, e_hold:8'h40, e_pend:1, e_ovf:1'b0});
    tbl.push_back(vec_t'{v:8'h00, dv:32'h00, e_valid:1'b1, e_tag:6, e_data:32'h24, e_hold:8'h00, e_pend:0, e_ovf:1'b0});
    tbl.push_back(vec_t'{v:8'h82, dv:32'h10, e_valid:1'b1, e_tag:7, e_data:32'h17, e_hold:8'h02, e_pend:1, e_ovf:1'b0});
    tbl.push_back(vec_t'{v:8'h00, dv:32'h00, e_valid:1'b1, e_tag:1, e_data:32'h11, e_hold:8'h00, e_pend:0, e_ovf:1'b0});
    tbl.push_back(vec_t'{v:8'h14, dv:32'h06, e_valid:1'b1, e_tag:2, e_data:32'h08, e_hold:8'h10, e_pend:1, e_ovf:1'b0});
    tbl.push_back(vec_t'{v:8'h18, dv:32'h07, e_valid:1'b1, e_tag:3, e_data:32'h0A, e_hold:8'h10, e_pend:1, e_ovf:1'b1});
    tbl.push_back(vec_t'{v:8'h00, dv:32'h00, e_valid:1'b1, e_tag:4, e_data:32'h0A, e_hold:8'h00, e_pend:0, e_ovf:1'b1});
    tbl.push_back(vec_t'{v:8'h30, dv:32'h0D, e_valid:1'b1, e_tag:5, e_data:32'h12, e_hold:8'h10, e_pend:1, e_ovf:1'b1});
    tbl.push_back(vec_t'{v:8'h10, dv:32'h1E, e_valid:1'b1, e_tag:4, e_data:32'h11, e_hold:8'h10, e_pend:1, e_ovf:1'b1});
    tbl.push_back(vec_t'{v:8'h00, dv:32'h00, e_valid:1'b1, e_tag:4, e_data:32'h22, e_hold:8'h00, e_pend:0, e_ovf:1'b1});
    tbl.push_back(vec_t'{v:8'h01, dv:32'h05, e_valid:1'b0, e_tag:0, e_data:32'h00, e_hold:8'h00, e_pend:0, e_ovf:1'b1});

    #12;
    checkOutput("por", 1'b0, 0, 32'h0, '0, 0, 1'b0);
    rstn = 1'b1;

    for (int n = 0; n < tbl.size(); n++) begin
      applyStimulus(tbl[n].v, mk_data(tbl[n].dv));
      checkOutput($sformatf("vec%0d", n), tbl[n].e_valid, tbl[n].e_tag, tbl[n].e_data,
                  tbl[n].e_hold, tbl[n].e_pend, tbl[n].e_ovf);
    end

    // Fill three slots, then pull reset low between edges.
    applyStimulus(8'h0E, mk_data(32'h0));
    checkOutput("burst1", 1'b1, 1, 32'h1, 8'h0C, 2, 1'b1);
    applyStimulus(8'h70, mk_data(32'h0));
    checkOutput("burst2", 1'b1, 2, 32'h2, 8'h78, 4, 1'b1);
    #2 rstn = 1'b0;
    #1 checkOutput("async_reset", 1'b0, 0, 32'h0, '0, 0, 1'b0);
    #4 rstn = 1'b1;
    for (int n = 0; n < 4; n++) begin
      applyStimulus('0, mk_data(32'h0));
      checkOutput($sformatf("post_reset%0d", n), 1'b0, 0, 32'h0, '0, 0, 1'b0);
    end
    for (int n = 0; n < 3; n++) begin
      applyStimulus(8'h01, mk_data(32'hFF));
      checkOutput($sformatf("unit0_%0d", n), 1'b0, 0, 32'h0, '0, 0, 1'b0);
    end

    model_reset();
    for (int c = 0; c < 600; c++) begin
      logic [NUM_FU-1:0] v;
      data_vec_t         d;
      case ($urandom_range(0, 2))
        0:       v = NUM_FU'($urandom) & NUM_FU'($urandom);
        1:       v = NUM_FU'($urandom);
        default: v = NUM_FU'($urandom) & NUM_FU'($urandom) & NUM_FU'($urandom);
      endcase
      if ($urandom_range(0, 9) != 0) v = v & ~bus.fu_hold;
      for (int i = 0; i < NUM_FU; i++) d[i] = $urandom;
      model_step(v, d);
      applyStimulus(v, d);
      checkOutput($sformatf("rand%0d", c), m_valid, m_tag, m_data, model_hold(), model_pend(), m_ovf);
      for (int i = 1; i < NUM_FU; i++) begin
        if (bus.cdb_valid && bus.cdb_tag == TAG_W'(i)) begin
          n_checks++;
          if (wait_cnt[i] > FAIR_BOUND) begin
            n_errors++;
            $display("[TB] FAIL fairness tag %0d: waited %0d cycles, bound %0d", i, wait_cnt[i], FAIR_BOUND);
          end
          wait_cnt[i] = 0;
        end else if (bus.fu_hold[i]) begin
          wait_cnt[i]++;
        end else begin
          wait_cnt[i] = 0;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
